exec_muldiv_unit: RTL and testbench
===================================

// Module: exec_muldiv_unit
// PURPOSE
//  Iterative multiply/divide unit in the execute stage, fed directly by the dec2exec pipeline register.
//  Executes MULT/MULTU/DIV/DIVU and MTHI/MTLO, and owns the architectural HI/LO registers.
//  Requests a pipeline stall while an iteration is in flight.
//  Reports completion with the active-list index so the instruction retires in order.
// PARAMETERS
//  DATA_WIDTH       32  operand and HI/LO width; iteration count = DATA_WIDTH
//  FREE_LIST_WIDTH  3   width of the active-list index tag
// PORTS
//  clk                    in   1                clock, rising edge
//  rst_n                  in   1                reset, asynchronous, active-low
//  flush                  in   1                stage flush (branch mispredict)
//  global_flush           in   1                exception/global flush
//  start                  in   1                exec holds a muldiv-class instruction
//  op                     in   3                0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, others NOP
//  alu_rs                 in   DATA_WIDTH       rs operand from dec2exec (dividend / multiplicand / MT source)
//  alu_rt                 in   DATA_WIDTH       rt operand from dec2exec (divisor / multiplier)
//  active_list_index_in   in   FREE_LIST_WIDTH  tag of the issuing instruction
//  stall_req              out  1                freezes fetch, decode and dec2exec (combinational)
//  done                   out  1                one-cycle completion pulse
//  active_list_index_out  out  FREE_LIST_WIDTH  tag latched at start; valid with done
//  hi                     out  DATA_WIDTH       HI register
//  lo                     out  DATA_WIDTH       LO register
//  div_zero               out  1                only when MULDIV_DIVZERO_TRAP_EN is defined
// BEHAVIOUR
//  Reset: state=IDLE; hi=lo=0; done=0; active_list_index_out=0; div_zero=0; internal accumulators 0.
//  States: IDLE, MUL, DIV, FIXUP, DONE.
//  IDLE, start && op in {0..3}:
//   - Latch |rs| and |rt| (magnitudes for signed ops; raw values for unsigned ops).
//   - Latch the sign flags and the tag.
//   - Iteration counter cnt=0; go to MUL or DIV.
//  IDLE, start && op=4/5: HI (or LO) <= alu_rs at the edge; pulse done next cycle; stays IDLE; no stall.
//  MUL: radix-2 shift-add, one bit per cycle, 2*DATA_WIDTH-bit product; after DATA_WIDTH cycles -> FIXUP.
//  DIV: restoring division, one quotient bit per cycle; after DATA_WIDTH cycles -> FIXUP.
//  FIXUP:
//   - Signed ops: negate the product if sign(rs)^sign(rt).
//   - Quotient sign = sign(rs)^sign(rt); remainder sign = sign(rs).
//   - HI/LO are written at the FIXUP->DONE edge: mul {HI,LO}=product; div LO=quotient, HI=remainder.
//  DONE: done=1 for one cycle -> IDLE.
//  Latency: start accepted at edge 0; done is high in the cycle after edge DATA_WIDTH+2 (mul/div).
//  stall_req = (state in {MUL,DIV,FIXUP}) || (state==IDLE && start && op in {0..3}).
//   - Deasserted in DONE, so dec2exec advances on the DONE edge; start is ignored in DONE.
//  start while in MUL/DIV/FIXUP: ignored (upstream is frozen).
//  Divide by zero (rt==0, op 2/3):
//   - IDLE -> DONE directly, no iterations.
//   - HI <= alu_rs, LO <= all-ones, sign ignored.
//  flush || global_flush in any state:
//   - Next state IDLE; HI/LO unchanged; no done pulse.
//   - Flush has priority over a simultaneous start, and over the FIXUP->DONE HI/LO write.
//  Signed -2^(W-1)/-1: quotient wraps to -2^(W-1), remainder 0; no exception.
// CONFIGURATION
//  `MULDIV_DIVZERO_TRAP_EN defined:
//   - Divide by zero leaves HI/LO unchanged.
//   - div_zero pulses together with done; the commit stage raises a trap.
//  Not defined: the div_zero port is absent and divide by zero writes the values above.
// STRUCTURE
//  defines.v: MULDIV_OP_* encodings and the state encodings.
//  Sub-module muldiv_abs_neg: combinational magnitude/negate helper, instanced for operand and result fixup.
//  FSM, counter and datapath stay in exec_muldiv_unit.
// TESTING
//  MULT rs=-3, rt=7 -> done at cycle 35; {HI,LO}=0xFFFFFFFF_FFFFFFEB; stall_req high cycles 0..33.
//  DIVU rs=100, rt=7 -> LO=14, HI=2; DIV rs=-7, rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
//  DIV by zero, rs=5 -> done at cycle 2; HI=5, LO=0xFFFFFFFF (macro on: HI/LO unchanged, div_zero=1).
//  MULTU started, global_flush at cycle 10 -> IDLE next cycle, no done, HI/LO keep prior values.
//  MTLO 0x1234 then MULT back-to-back -> LO=0x1234 one cycle later; MULT accepted with no lost cycle.
//  rst_n low mid-DIV -> all outputs 0 immediately; first start after release completes normally.

Source files
------------

// File: rtl/exec_muldiv_unit_pkg.sv
// Shared encodings for the execute-stage multiply/divide unit.
// Op codes mirror the dec2exec muldiv op field; states cover the iterative FSM.
package exec_muldiv_unit_pkg;
    localparam logic [2:0] MULDIV_OP_MULT  = 3'd0;
    localparam logic [2:0] MULDIV_OP_MULTU = 3'd1;
    localparam logic [2:0] MULDIV_OP_DIV   = 3'd2;
    localparam logic [2:0] MULDIV_OP_DIVU  = 3'd3;
    localparam logic [2:0] MULDIV_OP_MTHI  = 3'd4;
    localparam logic [2:0] MULDIV_OP_MTLO  = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIXUP,
        S_DONE
    } muldiv_state_e;

    function automatic logic is_arith_op(input logic [2:0] op);
        return op <= MULDIV_OP_DIVU;
    endfunction

    function automatic logic is_signed_op(input logic [2:0] op);
        return (op == MULDIV_OP_MULT) || (op == MULDIV_OP_DIV);
    endfunction
endpackage

// File: rtl/exec_muldiv_unit_if.sv
// dec2exec-side bundle of the multiply/divide unit; master = pipeline, slave = unit.
// div_zero exists only when MULDIV_DIVZERO_TRAP_EN is defined.
interface exec_muldiv_unit_if #(
    parameter int DATA_WIDTH      = 32,
    parameter int FREE_LIST_WIDTH = 3
);
    logic                       flush;
    logic                       global_flush;
    logic                       start;
    logic [2:0]                 op;
    logic [DATA_WIDTH-1:0]      alu_rs;
    logic [DATA_WIDTH-1:0]      alu_rt;
    logic [FREE_LIST_WIDTH-1:0] active_list_index_in;
    logic                       stall_req;
    logic                       done;
    logic [FREE_LIST_WIDTH-1:0] active_list_index_out;
    logic [DATA_WIDTH-1:0]      hi;
    logic [DATA_WIDTH-1:0]      lo;
`ifdef MULDIV_DIVZERO_TRAP_EN
    logic                       div_zero;

    modport master (output flush, global_flush, start, op, alu_rs, alu_rt, active_list_index_in,
                    input  stall_req, done, active_list_index_out, hi, lo, div_zero);
    modport slave  (input  flush, global_flush, start, op, alu_rs, alu_rt, active_list_index_in,
                    output stall_req, done, active_list_index_out, hi, lo, div_zero);
`else
    modport master (output flush, global_flush, start, op, alu_rs, alu_rt, active_list_index_in,
                    input  stall_req, done, active_list_index_out, hi, lo);
    modport slave  (input  flush, global_flush, start, op, alu_rs, alu_rt, active_list_index_in,
                    output stall_req, done, active_list_index_out, hi, lo);
`endif
endinterface

// File: rtl/exec_muldiv_unit_abs_neg.sv
// Conditional two's-complement negate: magnitude of a signed operand, or sign fixup of a result.
module muldiv_abs_neg #(
    parameter int W = 32
) (
    input  logic [W-1:0] i_val,
    input  logic         i_neg,
    output logic [W-1:0] o_val
);
    assign o_val = i_neg ? (~i_val + {{(W-1){1'b0}}, 1'b1}) : i_val;
endmodule

// File: rtl/exec_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; one bit per cycle, stalls upstream while busy.
// Optional MULDIV_DIVZERO_TRAP_EN: divide by zero keeps HI/LO and pulses div_zero with done.
module exec_muldiv_unit
    import exec_muldiv_unit_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int FREE_LIST_WIDTH = 3
) (
    input logic               clk,
    input logic               rst_n,
    exec_muldiv_unit_if.slave bus
);
    localparam int W     = DATA_WIDTH;
    localparam int CNT_W = $clog2(DATA_WIDTH);

    muldiv_state_e              r_state;
    logic [CNT_W-1:0]           r_cnt;
    logic [W-1:0]               r_opnd;
    logic [2*W-1:0]             r_acc;
    logic                       r_neg_q;
    logic                       r_neg_r;
    logic                       r_is_div;
    logic [W-1:0]               r_hi;
    logic [W-1:0]               r_lo;
    logic                       r_done;
    logic [FREE_LIST_WIDTH-1:0] r_tag;
`ifdef MULDIV_DIVZERO_TRAP_EN
    logic                       r_dz_pend;
    logic                       r_divz;
`endif

    logic           w_sgn;
    logic           w_flush;
    logic           w_rt_zero;
    logic [W-1:0]   w_abs_rs;
    logic [W-1:0]   w_abs_rt;
    logic [W:0]     w_mul_sum;
    logic [2*W-1:0] w_mul_next;
    logic [W:0]     w_div_sh;
    logic [W:0]     w_div_diff;
    logic [2*W-1:0] w_div_next;
    logic [2*W-1:0] w_prod;
    logic [W-1:0]   w_quot;
    logic [W-1:0]   w_rem;

    assign w_sgn     = is_signed_op(bus.op);
    assign w_flush   = bus.flush | bus.global_flush;
    assign w_rt_zero = (bus.alu_rt == '0);

    muldiv_abs_neg #(.W(W)) u_abs_rs (
        .i_val(bus.alu_rs), .i_neg(w_sgn & bus.alu_rs[W-1]), .o_val(w_abs_rs));
    muldiv_abs_neg #(.W(W)) u_abs_rt (
        .i_val(bus.alu_rt), .i_neg(w_sgn & bus.alu_rt[W-1]), .o_val(w_abs_rt));

    // Shift-add: upper half accumulates the multiplicand, multiplier drains out of the lower half.
    assign w_mul_sum  = {1'b0, r_acc[2*W-1:W]} + {1'b0, (r_acc[0] ? r_opnd : {W{1'b0}})};
    assign w_mul_next = {w_mul_sum, r_acc[W-1:1]};

    // Restoring divide: {rem, quot} shifts left, quotient bits enter at the bottom.
    assign w_div_sh   = {r_acc[2*W-1:W], r_acc[W-1]};
    assign w_div_diff = w_div_sh - {1'b0, r_opnd};
    assign w_div_next = w_div_diff[W] ? {w_div_sh[W-1:0],   r_acc[W-2:0], 1'b0}
                                      : {w_div_diff[W-1:0], r_acc[W-2:0], 1'b1};

    muldiv_abs_neg #(.W(2*W)) u_fix_prod (.i_val(r_acc),          .i_neg(r_neg_q), .o_val(w_prod));
    muldiv_abs_neg #(.W(W))   u_fix_quot (.i_val(r_acc[W-1:0]),   .i_neg(r_neg_q), .o_val(w_quot));
    muldiv_abs_neg #(.W(W))   u_fix_rem  (.i_val(r_acc[2*W-1:W]), .i_neg(r_neg_r), .o_val(w_rem));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_opnd   <= '0;
            r_acc    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_is_div <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
            r_tag    <= '0;
`ifdef MULDIV_DIVZERO_TRAP_EN
            r_dz_pend <= 1'b0;
            r_divz    <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
`ifdef MULDIV_DIVZERO_TRAP_EN
            r_divz <= 1'b0;
`endif
            if (w_flush) begin
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: if (bus.start) begin
                        if (is_arith_op(bus.op)) begin
                            r_tag    <= bus.active_list_index_in;
                            r_cnt    <= '0;
                            r_is_div <= bus.op[1];
                            r_neg_q  <= w_sgn & (bus.alu_rs[W-1] ^ bus.alu_rt[W-1]);
                            r_neg_r  <= w_sgn & bus.alu_rs[W-1];
`ifdef MULDIV_DIVZERO_TRAP_EN
                            r_dz_pend <= bus.op[1] & w_rt_zero;
`endif
                            if (!bus.op[1]) begin
                                r_opnd  <= w_abs_rs;
                                r_acc   <= {{W{1'b0}}, w_abs_rt};
                                r_state <= S_MUL;
                            end else if (w_rt_zero) begin
`ifndef MULDIV_DIVZERO_TRAP_EN
                                r_hi <= bus.alu_rs;
                                r_lo <= '1;
`endif
                                r_state <= S_DONE;
                            end else begin
                                r_opnd  <= w_abs_rt;
                                r_acc   <= {{W{1'b0}}, w_abs_rs};
                                r_state <= S_DIV;
                            end
                        end else if (bus.op == MULDIV_OP_MTHI || bus.op == MULDIV_OP_MTLO) begin
                            if (bus.op == MULDIV_OP_MTHI) r_hi <= bus.alu_rs;
                            else                          r_lo <= bus.alu_rs;
                            r_tag  <= bus.active_list_index_in;
                            r_done <= 1'b1;
                        end
                    end
                    S_MUL: begin
                        r_acc <= w_mul_next;
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == CNT_W'(W-1)) r_state <= S_FIXUP;
                    end
                    S_DIV: begin
                        r_acc <= w_div_next;
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == CNT_W'(W-1)) r_state <= S_FIXUP;
                    end
                    S_FIXUP: begin
                        if (r_is_div) begin
                            r_hi <= w_rem;
                            r_lo <= w_quot;
                        end else begin
                            r_hi <= w_prod[2*W-1:W];
                            r_lo <= w_prod[W-1:0];
                        end
                        r_state <= S_DONE;
                    end
                    S_DONE: begin
                        r_done <= 1'b1;
`ifdef MULDIV_DIVZERO_TRAP_EN
                        r_divz <= r_dz_pend;
`endif
                        r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.stall_req = (r_state == S_MUL) || (r_state == S_DIV) || (r_state == S_FIXUP) ||
                           ((r_state == S_IDLE) && bus.start && is_arith_op(bus.op));
    assign bus.done                  = r_done;
    assign bus.active_list_index_out = r_tag;
    assign bus.hi                    = r_hi;
    assign bus.lo                    = r_lo;
`ifdef MULDIV_DIVZERO_TRAP_EN
    assign bus.div_zero = r_divz;
`endif
endmodule

// File: tb/tb_exec_muldiv_unit.sv
// Directed + random checks of exec_muldiv_unit against a plain-arithmetic HI/LO/latency model.
module tb_exec_muldiv_unit;
    localparam int W  = 32;
    localparam int FL = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    exec_muldiv_unit_if #(.DATA_WIDTH(W), .FREE_LIST_WIDTH(FL)) bus ();
    exec_muldiv_unit #(.DATA_WIDTH(W), .FREE_LIST_WIDTH(FL)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_cmp = 0;
    int n_err = 0;
    logic [W-1:0] exp_hi = '0;
    logic [W-1:0] exp_lo = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one instruction at the current cycle (cycle 0) and follow it to completion.
    task automatic run_op(input string name, input logic [2:0] op, input logic [W-1:0] rs,
                          input logic [W-1:0] rt, input logic [FL-1:0] tag, input int flush_at);
        int cyc = 0, done_cyc = -1, stall_last = -1, e_done, e_stall;
        logic [FL-1:0] tag_seen = '0;
        logic dz_seen = 1'b0;
        logic arith = (op <= 3'd3);
        logic dz = (op == 3'd2 || op == 3'd3) && rt == 0;
        logic [63:0] p;
        longint q, r;
        // Reference: what the instruction should leave in HI/LO, and when it should finish.
        if (flush_at >= 0) begin
            e_done  = -1;
            e_stall = arith ? flush_at : -1;
        end else begin
            e_done  = dz ? 2 : arith ? W + 3 : (op == 3'd4 || op == 3'd5) ? 1 : -1;
            e_stall = dz ? 0 : arith ? W + 1 : -1;
            case (op)
                3'd0: begin p = longint'(int'(rs)) * longint'(int'(rt)); {exp_hi, exp_lo} = p; end
                3'd1: begin p = {32'b0, rs} * {32'b0, rt}; {exp_hi, exp_lo} = p; end
                3'd2, 3'd3: if (dz) begin
`ifndef MULDIV_DIVZERO_TRAP_EN
                    exp_hi = rs; exp_lo = '1;
`endif
                end else if (op == 3'd2) begin
                    q = longint'(int'(rs)) / longint'(int'(rt));
                    r = longint'(int'(rs)) % longint'(int'(rt));
                    exp_lo = q[W-1:0]; exp_hi = r[W-1:0];
                end else begin
                    exp_lo = rs / rt; exp_hi = rs % rt;
                end
                3'd4: exp_hi = rs;
                3'd5: exp_lo = rs;
                default: ;
            endcase
        end
        bus.op = op; bus.alu_rs = rs; bus.alu_rt = rt; bus.active_list_index_in = tag;
        bus.start = 1'b1; bus.global_flush = (flush_at == 0);
        #1;
        if (bus.stall_req) stall_last = 0;
        while (cyc < 60 && done_cyc < 0) begin
            @(posedge clk);
            cyc++;
            #1;
            bus.start = 1'b0;
            bus.global_flush = (cyc == flush_at);
            #1;
            if (bus.done) begin
                done_cyc = cyc;
                tag_seen = bus.active_list_index_out;
`ifdef MULDIV_DIVZERO_TRAP_EN
                dz_seen = bus.div_zero;
`endif
            end
            if (bus.stall_req) stall_last = cyc;
        end
        bus.global_flush = 1'b0;
        chk({name, ".done_cycle"}, 64'(done_cyc), 64'(e_done));
        chk({name, ".stall_last"}, 64'(stall_last), 64'(e_stall));
        if (e_done >= 0) chk({name, ".tag"}, 64'(tag_seen), 64'(tag));
`ifdef MULDIV_DIVZERO_TRAP_EN
        if (e_done >= 0) chk({name, ".div_zero"}, 64'(dz_seen), 64'(dz));
`else
        if (dz_seen) chk({name, ".div_zero"}, 64'(dz_seen), 64'(0));
`endif
        chk({name, ".hi"}, 64'(bus.hi), 64'(exp_hi));
        chk({name, ".lo"}, 64'(bus.lo), 64'(exp_lo));
        @(posedge clk);
        #1;
        chk({name, ".done_pulse"}, 64'(bus.done), 64'(0));
    endtask

    initial begin
        bus.flush = 1'b0; bus.global_flush = 1'b0; bus.start = 1'b0; bus.op = '0;
        bus.alu_rs = '0; bus.alu_rt = '0; bus.active_list_index_in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.hi", 64'(bus.hi), 64'(0));
        chk("reset.lo", 64'(bus.lo), 64'(0));
        chk("reset.done", 64'(bus.done), 64'(0));
        chk("reset.tag", 64'(bus.active_list_index_out), 64'(0));
        chk("reset.stall", 64'(bus.stall_req), 64'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op("mult_m3x7", 3'd0, 32'hFFFF_FFFD, 32'd7, 3'd5, -1);
        chk("mult_m3x7.abs", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op("divu_100_7", 3'd3, 32'd100, 32'd7, 3'd1, -1);
        chk("divu_100_7.abs", {bus.hi, bus.lo}, {32'd2, 32'd14});
        run_op("div_m7_2", 3'd2, 32'hFFFF_FFF9, 32'd2, 3'd2, -1);
        chk("div_m7_2.abs", {bus.hi, bus.lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        run_op("div_minint_m1", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 3'd3, -1);
        run_op("divzero", 3'd2, 32'd5, 32'd0, 3'd4, -1);
        run_op("multu_flush10", 3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 3'd6, 10);
        run_op("mthi_flush0", 3'd4, 32'hDEAD_BEEF, 32'd0, 3'd7, 0);
        run_op("nop", 3'd6, 32'h5555_5555, 32'd1, 3'd0, -1);
        run_op("mthi", 3'd4, 32'hCAFE_F00D, 32'd0, 3'd2, -1);

        // MTLO followed immediately by MULT: LO visible next cycle, MULT issued in that same cycle.
        bus.op = 3'd5; bus.alu_rs = 32'h1234; bus.active_list_index_in = 3'd3; bus.start = 1'b1;
        exp_lo = 32'h1234;
        @(posedge clk);
        #1;
        chk("mtlo.lo", 64'(bus.lo), 64'h1234);
        chk("mtlo.done", 64'(bus.done), 64'(1));
        run_op("mult_b2b", 3'd0, 32'h7FFF_FFFF, 32'h8000_0000, 3'd4, -1);

        // Reset mid-divide, then a normal operation.
        bus.op = 3'd2; bus.alu_rs = 32'd1000; bus.alu_rt = 32'd3; bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid.hi", 64'(bus.hi), 64'(0));
        chk("rst_mid.lo", 64'(bus.lo), 64'(0));
        chk("rst_mid.done", 64'(bus.done), 64'(0));
        chk("rst_mid.stall", 64'(bus.stall_req), 64'(0));
        chk("rst_mid.tag", 64'(bus.active_list_index_out), 64'(0));
        exp_hi = '0; exp_lo = '0;
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_op("after_rst", 3'd3, 32'hFFFF_FFFF, 32'd16, 3'd1, -1);

        for (int i = 0; i < 14; i++) begin
            logic [2:0] rop = 3'($urandom_range(0, 3));
            logic [W-1:0] rrs = $urandom;
            logic [W-1:0] rrt = (i % 3 == 0) ? W'($urandom_range(0, 15)) : $urandom;
            run_op($sformatf("rand%0d", i), rop, rrs, rrt, 3'($urandom_range(0, 7)), -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
